// File: rtl/fifo_rd_stream_if.sv
// Valid/ready word stream leaving the FIFO read-side drain controller.
// A word transfers on any rising clock edge where m_valid && m_ready; the master holds
// m_data stable while m_valid && !m_ready.
interface fifo_rd_stream_if #(
  parameter int data_width = 8
);
  logic                  m_valid;
  logic [data_width-1:0] m_data;
  logic                  m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller: pops the async FIFO, absorbs its one-cycle read latency in a
// 2-entry in-order buffer (head/tail) and streams the words out under backpressure.
module fifo_rd_stream #(
  parameter int data_width = 8,
  parameter int ptr_width  = 8
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [data_width-1:0] data_out,
  output logic                  r_en,
  fifo_rd_stream_if.master      m,
  output logic [ptr_width:0]    rd_count,
  output logic                  rd_err,
  output logic [1:0]            dbg_occ,
  output logic                  dbg_inflight
);

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;

  localparam logic [ptr_width:0] cnt_one = {{ptr_width{1'b0}}, 1'b1};

  occ_t                  occ;
  occ_t                  occ_next;
  logic                  inflight;
  logic                  pop;
  logic [data_width-1:0] head;
  logic [data_width-1:0] tail;

  assign pop          = m.m_valid && m.m_ready;
  assign m.m_valid    = (occ != OCC_0);
  assign m.m_data     = head;
  assign dbg_occ      = occ;
  assign dbg_inflight = inflight;

  // occ_next = occ + inflight - pop; pop only happens when occ is nonzero
  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_0: if (inflight) occ_next = OCC_1;
      OCC_1: begin
        if (inflight && !pop)      occ_next = OCC_2;
        else if (!inflight && pop) occ_next = OCC_0;
      end
      OCC_2: if (pop && !inflight) occ_next = OCC_1;
      default: occ_next = OCC_0;
    endcase
  end

  // A pop is only issued if its word is guaranteed a slot next cycle.
  always_comb begin
    r_en = 1'b0;
    if (!r_rst && enable && !empty && (occ_next != OCC_2)) r_en = 1'b1;
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      occ      <= OCC_0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      rd_count <= '0;
      rd_err   <= 1'b0;
    end else begin
      occ      <= occ_next;
      inflight <= r_en;
      if (r_en) rd_count <= rd_count + cnt_one;
      // Diagnostic only: the in-flight word is still captured below.
      if (inflight && empty) rd_err <= 1'b1;
      // head is always the oldest word; a capture lands in the slot after the tail.
      case (occ)
        OCC_0: if (inflight) head <= data_out;
        OCC_1: begin
          if (inflight) begin
            if (pop) head <= data_out;
            else     tail <= data_out;
          end
        end
        OCC_2: begin
          if (pop) begin
            head <= tail;
            if (inflight) tail <= data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: small FIFO read-side model, directed vector table for the
// basic stream, and hand-written sequences for backpressure, enable, wrap, reset and error.
module tb_fifo_rd_stream;

  logic       rclk;
  logic       r_rst;
  logic       enable;
  logic       empty;
  logic [7:0] data_out;
  logic       r_en;
  logic [8:0] rd_count;
  logic       rd_err;
  logic [1:0] dbg_occ;
  logic       dbg_inflight;

  fifo_rd_stream_if #(.data_width(8)) s_if ();

  fifo_rd_stream #(.data_width(8), .ptr_width(8)) dut (
    .rclk         (rclk),
    .r_rst        (r_rst),
    .enable       (enable),
    .empty        (empty),
    .data_out     (data_out),
    .r_en         (r_en),
    .m            (s_if),
    .rd_count     (rd_count),
    .rd_err       (rd_err),
    .dbg_occ      (dbg_occ),
    .dbg_inflight (dbg_inflight)
  );

  // clock / reset
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // FIFO read-side model: one-cycle read latency, read side cleared by reset
  logic [7:0] fmem [0:1023];
  int         wr_ptr;
  int         rd_ptr;
  logic       force_empty;

  assign empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      rd_ptr   <= wr_ptr;
      data_out <= 8'h00;
    end else if (r_en) begin
      data_out <= fmem[rd_ptr % 1024];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int         n_assert;
  int         n_fail;
  int         ren_total;
  int         acc_total;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       exp_ren;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [8:0] exp_cnt;
  } vec_t;

  vec_t t1 [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample r_en and accepted words at the falling edge, land #1 after rising.
  task automatic step();
    @(negedge rclk);
    if (!r_rst) begin
      if (r_en) ren_total++;
      if (s_if.m_valid && s_if.m_ready) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL sb_extra: unexpected word 0x%0h, no word required", s_if.m_data);
        end else begin
          chk("sb_order", {24'h0, s_if.m_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr_ptr % 1024] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    r_rst  = 1'b1;
    exp_q.delete();
    @(posedge rclk);
    @(posedge rclk);
    #1;
    r_rst = 1'b0;
    #1;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0) && (c < budget)) begin
      step();
      c++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int base_r;
    int base_a;
    n_assert    = 0;
    n_fail      = 0;
    ren_total   = 0;
    acc_total   = 0;
    wr_ptr      = 0;
    force_empty = 1'b0;
    r_rst       = 1'b1;
    enable      = 1'b0;
    s_if.m_ready = 1'b0;

    t1[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'd0};
    t1[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'd1};
    t1[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 9'd2};
    t1[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 9'd3};
    t1[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 9'd3};
    t1[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 9'd3};

    // reset values
    @(posedge rclk);
    #1;
    enable = 1'b1;
    #1;
    chk("rst_valid",    s_if.m_valid, 0);
    chk("rst_data",     s_if.m_data, 0);
    chk("rst_count",    rd_count, 0);
    chk("rst_err",      rd_err, 0);
    chk("rst_ren",      r_en, 0);
    chk("rst_occ",      dbg_occ, 0);
    chk("rst_inflight", dbg_inflight, 0);

    // basic stream of three words, vector table
    do_reset();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    for (int i = 0; i < 6; i++) begin
      enable       = t1[i].en;
      s_if.m_ready = t1[i].rdy;
      #1;
      chk($sformatf("t1_ren[%0d]", i),   r_en, t1[i].exp_ren);
      chk($sformatf("t1_valid[%0d]", i), s_if.m_valid, t1[i].exp_valid);
      chk($sformatf("t1_count[%0d]", i), rd_count, t1[i].exp_cnt);
      if (t1[i].exp_valid) chk($sformatf("t1_data[%0d]", i), s_if.m_data, t1[i].exp_data);
      step();
    end
    chk("t1_left", exp_q.size(), 0);

    // backpressure: ten words, m_ready low
    do_reset();
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    base_r = ren_total;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k >= 1) begin
        chk("t2_hold_valid", s_if.m_valid, 1);
        chk("t2_hold_data",  s_if.m_data, 8'h40);
      end
    end
    chk("t2_ren_twice", ren_total - base_r, 2);
    chk("t2_occ_full",  dbg_occ, 2);
    chk("t2_count2",    rd_count, 2);
    s_if.m_ready = 1'b1;
    #1;
    chk("t2_ren_reassert", r_en, 1);
    for (int k = 0; k < 10; k++) begin
      chk("t2_no_gap", s_if.m_valid, 1);
      step();
    end
    drain(20);
    chk("t2_count10", rd_count, 10);

    // enable dropped one cycle after the first pop
    do_reset();
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    base_r = ren_total;
    base_a = acc_total;
    enable = 1'b1;
    #1;
    chk("t3_first_pop", r_en, 1);
    step();
    enable = 1'b0;
    #1;
    chk("t3_stop", r_en, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_idle_ren", r_en, 0);
    end
    chk("t3_one_pop",  ren_total - base_r, 1);
    chk("t3_one_word", acc_total - base_a, 1);
    enable = 1'b1;
    drain(30);
    chk("t3_all_words", acc_total - base_a, 4);
    chk("t3_count",     rd_count, 4);

    // rd_count wrap after 2^9+3 pops
    do_reset();
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 515; i++) push(8'(i));
    base_r = ren_total;
    enable = 1'b1;
    drain(600);
    chk("t4_pops", ren_total - base_r, 515);
    chk("t4_wrap", rd_count, 3);

    // reset with the buffer full counting the word in flight
    do_reset();
    s_if.m_ready = 1'b0;
    push(8'h70);
    push(8'h71);
    push(8'h72);
    enable = 1'b1;
    step();
    step();
    chk("t5_pre_occ",      dbg_occ, 1);
    chk("t5_pre_inflight", dbg_inflight, 1);
    #1;
    r_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_rst_valid",    s_if.m_valid, 0);
    chk("t5_rst_data",     s_if.m_data, 0);
    chk("t5_rst_count",    rd_count, 0);
    chk("t5_rst_occ",      dbg_occ, 0);
    chk("t5_rst_inflight", dbg_inflight, 0);
    s_if.m_ready = 1'b1;
    push(8'hA5);
    #1;
    chk("t5_ren_in_rst", r_en, 0);
    r_rst = 1'b0;
    step();
    step();
    chk("t5_first_valid", s_if.m_valid, 1);
    chk("t5_first_data",  s_if.m_data, 8'hA5);
    drain(10);

    // empty seen high in the cycle after a pop
    do_reset();
    s_if.m_ready = 1'b1;
    push(8'h81);
    push(8'h82);
    enable = 1'b1;
    step();
    force_empty = 1'b1;
    #1;
    chk("t6_err_before", rd_err, 0);
    chk("t6_ren_gated",  r_en, 0);
    step();
    force_empty = 1'b0;
    chk("t6_err_set", rd_err, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_err_sticky", rd_err, 1);
    end
    drain(20);
    chk("t6_err_after_drain", rd_err, 1);
    do_reset();
    chk("t6_err_cleared", rd_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
